// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with pending scoreboard and sequential clear engine
module reg_file_mp #(
  parameter int NUMBER_OF_REGISTERS = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int NUM_READ_PORTS      = 2,
  parameter int ZERO_REG            = 1,
  parameter int BYPASS              = 1,
  localparam int AW                 = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ_PORTS*AW-1:0]         rs_address_i,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rs_data_o,
  output logic [NUM_READ_PORTS-1:0]            rs_pending_o,
  input  logic                                 rd_we_i,
  input  logic [AW-1:0]                        rd_address_i,
  input  logic [DATA_WIDTH-1:0]                rd_data_i,
  input  logic                                 rsv_we_i,
  input  logic [AW-1:0]                        rsv_address_i,
  input  logic                                 clr_i,
  output logic                                 clr_busy_o
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                    state;
  logic [DATA_WIDTH-1:0]     mem [NUMBER_OF_REGISTERS];
  logic [NUMBER_OF_REGISTERS-1:0] pend;
  logic [AW-1:0]             cnt;
  logic                      wr_ok, rsv_ok;
  assign wr_ok      = rd_we_i && (state == IDLE) && !((ZERO_REG != 0) && (rd_address_i == '0));
  assign rsv_ok     = rsv_we_i && (state == IDLE) && !((ZERO_REG != 0) && (rsv_address_i == '0));
  assign clr_busy_o = (state == CLEAR);
  // storage, scoreboard and clear engine; a clear start overrides any pend update of the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUMBER_OF_REGISTERS; i++) mem[i] <= '0;
      pend  <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (state == IDLE) begin
      if (wr_ok) mem[rd_address_i] <= rd_data_i;
      if (clr_i) begin
        pend  <= '0;
        cnt   <= '0;
        state <= CLEAR;
      end else begin
        if (wr_ok) pend[rd_address_i] <= 1'b0;
        if (rsv_ok) pend[rsv_address_i] <= 1'b1;
      end
    end else begin
      mem[cnt] <= '0;
      cnt      <= cnt + AW'(1);
      if (cnt == AW'(NUMBER_OF_REGISTERS - 1)) state <= IDLE;
    end
  end
  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          zero, byp;
    // combinational read with hardwired zero and same-cycle write forwarding
    always_comb begin
      a    = rs_address_i[k*AW +: AW];
      zero = (ZERO_REG != 0) && (a == '0);
      byp  = (BYPASS != 0) && rst && wr_ok && (rd_address_i == a);
      rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = zero ? '0 : byp ? rd_data_i : mem[a];
      rs_pending_o[k] = (zero || byp) ? 1'b0 : pend[a];
    end
  end
endmodule
